lcd_bus_writer: RTL and testbench
=================================

# lcd_bus_writer

Downstream consumer of the halfword selector in the LCD controller datapath. Accepts one 16-bit halfword plus a register-select flag over a valid/ready handshake and registers it. It then writes the halfword to the LCD parallel bus as two bytes, high byte first. Each byte gets a programmable setup / enable-pulse / hold sequence on `lcd_e`.

## Interface
- `SETUP_CYC`, default 2: cycles data/RS are stable with `lcd_e` low before the pulse; legal 1..255
- `PULSE_CYC`, default 4: cycles `lcd_e` is high; legal 1..255
- `HOLD_CYC`, default 2: cycles data/RS stay stable after `lcd_e` falls; legal 1..255

Ports:
- `clk` input 1: the only clock; all state updates on the rising edge
- `rst` input 1: synchronous, active-high reset
- `word_valid` input 1: `data_in`/`rs_in` hold a valid halfword
- `word_ready` output 1: block is idle and can accept a halfword
- `data_in` input 16: halfword from the selector stage
- `rs_in` input 1: LCD register select for this halfword (0 = command, 1 = data)
- `lcd_db` output 8: LCD data bus
- `lcd_rs` output 1: LCD register select
- `lcd_rw` output 1: LCD read/write; tied 0 (write only)
- `lcd_e` output 1: LCD enable strobe
- `word_done` output 1: one-cycle pulse when the last byte's hold phase completes

## Operation
- **States:** IDLE, SETUP, PULSE, HOLD.
- **Byte index:** 1 bit, or 2 bits in nibble mode. Phase counter: 8 bits.
- **IDLE:**
  - `word_ready`=1.
  - On `word_valid`&&`word_ready`, `data_in` and `rs_in` are captured into internal registers, the byte index clears and the block enters SETUP.
  - `data_in` changes after acceptance have no effect.
- **SETUP:** `lcd_db` = current byte, `lcd_rs` = captured rs, `lcd_e`=0. Lasts SETUP_CYC cycles, then PULSE.
- **PULSE:** same bus values, `lcd_e`=1. Lasts PULSE_CYC cycles, then HOLD.
- **HOLD:** same bus values, `lcd_e`=0. Lasts HOLD_CYC cycles.
  - If this is not the last byte, the index increments and the block returns to SETUP.
  - If it is the last byte, the block goes to IDLE and `word_done` pulses.
- **Byte order:** `data_in[15:8]`, then `data_in[7:0]`.
- **In IDLE:** `lcd_db` and `lcd_rs` keep their last driven values and `lcd_e`=0.
- **Outputs:** all registered; no combinational path from inputs to outputs.
- **`word_ready`:** low throughout SETUP/PULSE/HOLD; `word_valid` is ignored there.

## Timing
- **Reset values:** `word_ready`=0 while `rst` is high and 1 from the first cycle after release. `lcd_db`=8'h00, `lcd_rs`=0, `lcd_rw`=0, `lcd_e`=0, `word_done`=0. State = IDLE, index and counter = 0.
- **Per byte:** B = SETUP_CYC+PULSE_CYC+HOLD_CYC cycles. With the defaults B = 8.
- **Latency:**
  - The accept edge is at cycle 0.
  - Byte k occupies cycles k·B+1 .. (k+1)·B.
  - `word_done` is high in cycle N·B+1, where N = number of bytes (2, or 4 in nibble mode).
  - `word_ready` is high in that same cycle.
- **Back-to-back:** `word_valid` held high gives an accept every N·B+1 cycles. There is exactly one IDLE cycle between words.
- **Reset mid-operation:** the next edge forces the reset values. `lcd_e` drops immediately, the word is aborted, and no `word_done` is issued.
- **Counter:** loads (param−1) on phase entry and decrements to 0. Parameter 0 is illegal and unsupported.

## Configuration
- **`LCD_NIBBLE_MODE_EN` defined:**
  - 4-bit LCD interface; each byte is sent as two nibbles, upper first, each with the full SETUP/PULSE/HOLD sequence.
  - N = 4 transfers per word.
  - The nibble is driven on `lcd_db[7:4]`; `lcd_db[3:0]`=0.
- **Undefined:** 8-bit interface, N = 2, full byte on `lcd_db[7:0]`.

## Test plan
- **Reset release:** hold `rst` for 3 cycles, then release → `word_ready` is 0 during reset and 1 one cycle after release; `lcd_e`=0 and `lcd_db`=0.
- **Single word (defaults, 8-bit):** send `data_in`=16'hA55A, `rs_in`=1.
  - `lcd_db`=8'hA5 for cycles 1–8 with `lcd_e` high in cycles 3–6.
  - `lcd_db`=8'h5A for cycles 9–16 with `lcd_e` high in cycles 11–14.
  - `lcd_rs`=1 throughout; `word_done` and `word_ready` high in cycle 17.
- **Input isolation:** accept 16'h1234, then drive `data_in`=16'hFFFF from cycle 1 → the bus still shows 8'h12 then 8'h34.
- **Back-to-back:** `word_valid` held high with 16'h0001 then 16'h0203 → second accept at cycle 17; bytes 00, 01, 02, 03 in order; exactly two `word_done` pulses.
- **Reset mid-pulse:** assert `rst` in cycle 4 → `lcd_e`=0 from cycle 5, no `word_done`, and a new word accepted after release is sent correctly.
- **Nibble mode (`LCD_NIBBLE_MODE_EN`):** send 16'h1234 → `lcd_db[7:4]` = 1, 2, 3, 4 in cycles 1–8, 9–16, 17–24, 25–32; `lcd_db[3:0]`=0; `word_done` in cycle 33.

Source files
------------

// File: rtl/lcd_bus_if.sv
// Handshake and LCD parallel-bus bundle for lcd_bus_writer.
// master drives halfwords in; slave drives the LCD pins.
interface lcd_bus_if;
  logic        word_valid;
  logic        word_ready;
  logic [15:0] data_in;
  logic        rs_in;
  logic [7:0]  lcd_db;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_e;
  logic        word_done;

  modport master (
    output word_valid, data_in, rs_in,
    input  word_ready, lcd_db, lcd_rs,
    input  lcd_rw, lcd_e, word_done
  );

  modport slave (
    input  word_valid, data_in, rs_in,
    output word_ready, lcd_db, lcd_rs,
    output lcd_rw, lcd_e, word_done
  );
endinterface

// File: rtl/lcd_bus_writer.sv
// Writes a captured halfword to an LCD bus with setup/pulse/hold on lcd_e.
// Define LCD_NIBBLE_MODE_EN for a 4-bit bus (four nibble transfers).
module lcd_bus_writer #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int HOLD_CYC  = 2
) (
  input logic       clk,
  input logic       rst,
  lcd_bus_if.slave  bus
);

`ifdef LCD_NIBBLE_MODE_EN
  localparam int IDX_W = 2;
`else
  localparam int IDX_W = 1;
`endif

  localparam logic [IDX_W-1:0] LAST = '1;
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE, SETUP, PULSE, HOLD
  } state_t;

  state_t           state, state_n;
  logic [7:0]       cnt, cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [15:0]      data_q, data_n;
  logic             rs_q, rs_n;
  logic [7:0]       db_q, db_n;
  logic             e_q, e_n;
  logic             done_q, done_n;
  logic             ready_q;

  function automatic logic [7:0] pick(
    input logic [15:0]      d,
    input logic [IDX_W-1:0] i
  );
`ifdef LCD_NIBBLE_MODE_EN
    logic [3:0] n;
    unique case (i)
      2'd0:    n = d[15:12];
      2'd1:    n = d[11:8];
      2'd2:    n = d[7:4];
      default: n = d[3:0];
    endcase
    return {n, 4'h0};
`else
    return i ? d[7:0] : d[15:8];
`endif
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    data_n  = data_q;
    rs_n    = rs_q;
    e_n     = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.word_valid && ready_q) begin
          data_n  = bus.data_in;
          rs_n    = bus.rs_in;
          idx_n   = '0;
          cnt_n   = SETUP_LD;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (cnt == 8'd0) begin
          cnt_n   = PULSE_LD;
          state_n = PULSE;
          e_n     = 1'b1;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      PULSE: begin
        e_n = 1'b1;
        if (cnt == 8'd0) begin
          cnt_n   = HOLD_LD;
          state_n = HOLD;
          e_n     = 1'b0;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      HOLD: begin
        if (cnt == 8'd0) begin
          if (idx == LAST) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            idx_n   = idx + 1'b1;
            cnt_n   = SETUP_LD;
            state_n = SETUP;
          end
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    // bus keeps its last byte while idle
    db_n = (state_n == IDLE) ? db_q : pick(data_n, idx_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      idx     <= '0;
      data_q  <= 16'h0000;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
      e_q     <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      data_q  <= data_n;
      rs_q    <= rs_n;
      db_q    <= db_n;
      e_q     <= e_n;
      done_q  <= done_n;
      ready_q <= (state_n == IDLE);
    end
  end

  assign bus.word_ready = ready_q;
  assign bus.lcd_db     = db_q;
  assign bus.lcd_rs     = rs_q;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_e      = e_q;
  assign bus.word_done  = done_q;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed bench for lcd_bus_writer: cycle-exact bus waveform checks.
// Works in both 8-bit and LCD_NIBBLE_MODE_EN builds.
module tb_lcd_bus_writer;

  localparam int SU = 2;
  localparam int PU = 4;
  localparam int HO = 2;
  localparam int B  = SU + PU + HO;
`ifdef LCD_NIBBLE_MODE_EN
  localparam int N = 4;
`else
  localparam int N = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  lcd_bus_if bus ();

  lcd_bus_writer #(
    .SETUP_CYC(SU),
    .PULSE_CYC(PU),
    .HOLD_CYC (HO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_db(
    input logic [15:0] w,
    input int          k
  );
    logic [15:0] t;
`ifdef LCD_NIBBLE_MODE_EN
    t = w >> (12 - 4 * k);
    return {t[3:0], 4'h0};
`else
    t = w;
    return (k == 0) ? t[15:8] : t[7:0];
`endif
  endfunction

  // Called just after an accept edge; checks cycles 1..N*B+1.
  task automatic check_word(
    input logic [15:0] w,
    input logic        rs
  );
    int k;
    int p;
    for (int c = 1; c <= N * B + 1; c++) begin
      @(negedge clk);
      if (c <= N * B) begin
        k = (c - 1) / B;
        p = (c - 1) % B;
        check("db", 32'(bus.lcd_db), 32'(exp_db(w, k)));
        check("e", 32'(bus.lcd_e),
              32'(p >= SU && p < SU + PU));
        check("done", 32'(bus.word_done), 32'd0);
        check("ready", 32'(bus.word_ready), 32'd0);
      end else begin
        check("db_idle", 32'(bus.lcd_db),
              32'(exp_db(w, N - 1)));
        check("e_idle", 32'(bus.lcd_e), 32'd0);
        check("done_pulse", 32'(bus.word_done), 32'd1);
        check("ready_back", 32'(bus.word_ready), 32'd1);
      end
      check("rs", 32'(bus.lcd_rs), 32'(rs));
      check("rw", 32'(bus.lcd_rw), 32'd0);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.word_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(bus.word_ready), 32'd1);
  endtask

  // Accept one word; scramble drives data_in to FFFF after acceptance.
  task automatic send(
    input logic [15:0] w,
    input logic        rs,
    input logic        scramble
  );
    wait_ready();
    bus.word_valid = 1'b1;
    bus.data_in    = w;
    bus.rs_in      = rs;
    @(posedge clk);
    #1;
    bus.word_valid = 1'b0;
    if (scramble) begin
      bus.data_in = 16'hFFFF;
      bus.rs_in   = ~rs;
    end
    check_word(w, rs);
  endtask

  initial begin
    bus.word_valid = 1'b0;
    bus.data_in    = 16'h0000;
    bus.rs_in      = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", 32'(bus.word_ready), 32'd0);
      check("rst_e", 32'(bus.lcd_e), 32'd0);
      check("rst_db", 32'(bus.lcd_db), 32'd0);
      check("rst_done", 32'(bus.word_done), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", 32'(bus.word_ready), 32'd1);
    check("rel_rs", 32'(bus.lcd_rs), 32'd0);

    send(16'hA55A, 1'b1, 1'b0);
    send(16'h1234, 1'b0, 1'b1);

    // back-to-back with valid held high
    @(negedge clk);
    bus.word_valid = 1'b1;
    bus.data_in    = 16'h0001;
    bus.rs_in      = 1'b1;
    @(posedge clk);
    #1;
    check_word(16'h0001, 1'b1);
    bus.data_in = 16'h0203;
    @(posedge clk);
    #1;
    bus.word_valid = 1'b0;
    check_word(16'h0203, 1'b1);
    @(negedge clk);
    check("b2b_no_extra", 32'(bus.word_done), 32'd0);

    // reset in cycle 4, during the first pulse
    wait_ready();
    bus.word_valid = 1'b1;
    bus.data_in    = 16'hC3C3;
    bus.rs_in      = 1'b0;
    @(posedge clk);
    #1;
    bus.word_valid = 1'b0;
    for (int c = 1; c <= 3; c++) @(negedge clk);
    @(negedge clk);
    check("mid_e_hi", 32'(bus.lcd_e), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_e_lo", 32'(bus.lcd_e), 32'd0);
    check("mid_db", 32'(bus.lcd_db), 32'd0);
    check("mid_ready", 32'(bus.word_ready), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 2 * B; c++) begin
      @(negedge clk);
      check("abort_done", 32'(bus.word_done), 32'd0);
      check("abort_e", 32'(bus.lcd_e), 32'd0);
    end
    send(16'hBEEF, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
